// File: rtl/axi_wdata_issue_sync_128b_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_wdata_issue_sync_128b_pkg
// Purpose  : Shared widths, FIFO word layout and FSM state type for the
//            128b AXI write-data issuer.
// Contents : AXI_DATA_W, AXI_STRB_W, AXI_LEN_W, FIFO_W, STRB_LSB,
//            CMDQ_DEPTH, wstate_e
// Revision : 1.0 - initial release
// ============================================================================
package axi_wdata_issue_sync_128b_pkg;

    localparam int AXI_DATA_W = 128;
    localparam int AXI_STRB_W = AXI_DATA_W / 8;
    localparam int AXI_LEN_W  = 8;
    localparam int CMDQ_DEPTH = 4;

    // Data FIFO word is {strb, data}; strobes sit directly above the data.
    localparam int STRB_LSB   = AXI_DATA_W;
    localparam int FIFO_W     = AXI_DATA_W + AXI_STRB_W;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } wstate_e;

endpackage : axi_wdata_issue_sync_128b_pkg
`default_nettype wire

// File: rtl/axi_wdata_issue_sync_128b_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_wdata_issue_sync_128b_if
// Purpose  : AXI write-data (W) channel bundle.
// Signals  : m_axi_wvalid, m_axi_wready, m_axi_wdata, m_axi_wstrb,
//            m_axi_wlast
// Modports : master (issuer side), slave (interconnect / memory side)
// Revision : 1.0 - initial release
// ============================================================================
interface axi_wdata_issue_sync_128b_if #(
    parameter int DATA_W = axi_wdata_issue_sync_128b_pkg::AXI_DATA_W,
    parameter int STRB_W = axi_wdata_issue_sync_128b_pkg::AXI_STRB_W
) ();

    logic              m_axi_wvalid;
    logic              m_axi_wready;
    logic [DATA_W-1:0] m_axi_wdata;
    logic [STRB_W-1:0] m_axi_wstrb;
    logic              m_axi_wlast;

    modport master (
        output m_axi_wvalid,
        output m_axi_wdata,
        output m_axi_wstrb,
        output m_axi_wlast,
        input  m_axi_wready
    );

    modport slave (
        input  m_axi_wvalid,
        input  m_axi_wdata,
        input  m_axi_wstrb,
        input  m_axi_wlast,
        output m_axi_wready
    );

endinterface : axi_wdata_issue_sync_128b_if
`default_nettype wire

// File: rtl/axi_wdata_issue_sync_128b_wcmd_queue_sync.sv
`default_nettype none
// ============================================================================
// Module   : wcmd_queue_sync
// Purpose  : Flop-based FIFO holding burst lengths (beats-1) for the W
//            issuer. Head entry is visible on pop_data while !empty.
// Ports    : clk, rst (async, active-high), flush (sync clear),
//            push/push_data, pop/pop_data, full, empty
// Revision : 1.0 - initial release
// ============================================================================
module wcmd_queue_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             flush,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] push_data,
    input  wire logic             pop,
    output logic      [WIDTH-1:0] pop_data,
    output logic                  full,
    output logic                  empty
);
    import axi_wdata_issue_sync_128b_pkg::*;

    localparam int                c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]  c_depth = (c_ptr_w + 1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;

    logic w_push;
    logic w_pop;

    // A push into a full queue is refused even if a pop happens in the
    // same cycle; the freed slot shows up on the next cycle's !full.
    assign w_push   = push & ~full;
    assign w_pop    = pop & ~empty;
    assign full     = (r_count == c_depth);
    assign empty    = (r_count == '0);
    assign pop_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read behind the count.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= push_data;
    end

endmodule : wcmd_queue_sync
`default_nettype wire

// File: rtl/axi_wdata_issue_sync_128b.sv
`default_nettype none
// ============================================================================
// Module   : axi_wdata_issue_sync_128b
// Purpose  : Drains the {strb,data} write FIFO onto the AXI W channel.
//            Burst lengths come from a command queue filled alongside AW;
//            generates WLAST and a one-cycle burst_done per burst.
// Ports    : clk, rst (async, active-high), soft_init (sync flush)
//            cmd_valid/cmd_ready/cmd_len  - burst length queue input
//            fifo_pop/fifo_rdata/fifo_empty - FWFT data FIFO read side
//            m_axi (master modport)        - AXI W channel
//            burst_done                    - pulse after WLAST handshake
//            busy                          - work pending or in flight
// Revision : 1.0 - initial release
// ============================================================================
module axi_wdata_issue_sync_128b #(
    parameter int DATA_W     = axi_wdata_issue_sync_128b_pkg::AXI_DATA_W,
    parameter int STRB_W     = axi_wdata_issue_sync_128b_pkg::AXI_STRB_W,
    parameter int LEN_W      = axi_wdata_issue_sync_128b_pkg::AXI_LEN_W,
    parameter int CMDQ_DEPTH = axi_wdata_issue_sync_128b_pkg::CMDQ_DEPTH
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     soft_init,
    input  wire logic                     cmd_valid,
    output logic                          cmd_ready,
    input  wire logic [LEN_W-1:0]         cmd_len,
    output logic                          fifo_pop,
    input  wire logic [DATA_W+STRB_W-1:0] fifo_rdata,
    input  wire logic                     fifo_empty,
    axi_wdata_issue_sync_128b_if.master   m_axi,
    output logic                          burst_done,
    output logic                          busy
);
    import axi_wdata_issue_sync_128b_pkg::*;

    localparam int c_strb_lsb = DATA_W;

    wstate_e           r_state;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_beat_cnt;
    logic              r_wvalid;
    logic [DATA_W-1:0] r_wdata;
    logic [STRB_W-1:0] r_wstrb;
    logic              r_wlast;
    logic              r_burst_done;

    logic              w_q_full;
    logic              w_q_empty;
    logic [LEN_W-1:0]  w_q_head;
    logic              w_q_pop;
    logic              w_free;
    logic              w_pop;
    logic              w_last_beat;

    wcmd_queue_sync #(
        .WIDTH (LEN_W),
        .DEPTH (CMDQ_DEPTH)
    ) u_cmdq (
        .clk       (clk),
        .rst       (rst),
        .flush     (soft_init),
        .push      (cmd_valid),
        .push_data (cmd_len),
        .pop       (w_q_pop),
        .pop_data  (w_q_head),
        .full      (w_q_full),
        .empty     (w_q_empty)
    );

    // Output stage can take a new beat when empty or being drained now.
    assign w_free      = ~r_wvalid | m_axi.m_axi_wready;
    assign w_pop       = (r_state == ST_BURST) & ~fifo_empty & w_free;
    assign w_last_beat = (r_beat_cnt == r_len);

    // Head is consumed when starting from idle, or on the last beat of a
    // burst so the next burst starts without a bubble. The queue ignores
    // the pop when empty.
    assign w_q_pop = ((r_state == ST_IDLE) & ~w_q_empty) | (w_pop & w_last_beat);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_len        <= '0;
            r_beat_cnt   <= '0;
            r_wvalid     <= 1'b0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_wlast      <= 1'b0;
            r_burst_done <= 1'b0;
        end else if (soft_init) begin
            r_state      <= ST_IDLE;
            r_len        <= '0;
            r_beat_cnt   <= '0;
            r_wvalid     <= 1'b0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_wlast      <= 1'b0;
            r_burst_done <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_q_empty) begin
                        r_state    <= ST_BURST;
                        r_len      <= w_q_head;
                        r_beat_cnt <= '0;
                    end
                end
                ST_BURST: begin
                    if (w_pop) begin
                        if (w_last_beat) begin
                            r_beat_cnt <= '0;
                            if (!w_q_empty) r_len   <= w_q_head;
                            else            r_state <= ST_IDLE;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // Payload only changes on a load, so it is held during stalls.
            if (w_pop) begin
                r_wvalid <= 1'b1;
                r_wdata  <= fifo_rdata[DATA_W-1:0];
                r_wstrb  <= fifo_rdata[c_strb_lsb +: STRB_W];
                r_wlast  <= w_last_beat;
            end else if (m_axi.m_axi_wready) begin
                r_wvalid <= 1'b0;
            end

            r_burst_done <= r_wvalid & m_axi.m_axi_wready & r_wlast;
        end
    end

    assign cmd_ready          = ~w_q_full;
    assign fifo_pop           = w_pop;
    assign m_axi.m_axi_wvalid = r_wvalid;
    assign m_axi.m_axi_wdata  = r_wdata;
    assign m_axi.m_axi_wstrb  = r_wstrb;
    assign m_axi.m_axi_wlast  = r_wlast;
    assign burst_done         = r_burst_done;
    assign busy               = (r_state == ST_BURST) | ~w_q_empty | r_wvalid;

endmodule : axi_wdata_issue_sync_128b
`default_nettype wire

// File: tb/tb_axi_wdata_issue_sync_128b.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_wdata_issue_sync_128b
// Purpose  : Directed self-checking bench for axi_wdata_issue_sync_128b.
//            Models the FWFT data FIFO and scores every W beat against the
//            words loaded and the burst lengths issued.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_wdata_issue_sync_128b;

    logic         clk = 1'b0;
    logic         rst;
    logic         soft_init;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [7:0]   cmd_len;
    logic         fifo_pop;
    logic [143:0] fifo_rdata;
    logic         fifo_empty;
    logic         burst_done;
    logic         busy;

    axi_wdata_issue_sync_128b_if w_if ();

    axi_wdata_issue_sync_128b u_dut (
        .clk        (clk),
        .rst        (rst),
        .soft_init  (soft_init),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_len    (cmd_len),
        .fifo_pop   (fifo_pop),
        .fifo_rdata (fifo_rdata),
        .fifo_empty (fifo_empty),
        .m_axi      (w_if),
        .burst_done (burst_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [143:0] fq[$];     // data FIFO contents
    logic [143:0] exp_w[$];  // expected {strb,data} beat order
    logic         exp_l[$];  // expected wlast per beat

    int   pops, hs_cnt, done_cnt, acc, cyc, first_hs, last_hs, stalls;
    int   gap_at = -1;
    int   gap_left = 0;
    bit   gap_seen = 0;
    bit   toggle_rdy = 0;
    int   word_id = 0;
    logic prev_stall = 1'b0;
    logic prev_hs_last = 1'b0;
    logic [144:0] held = '0;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [143:0] mk_word(input int k);
        logic [31:0]  d32;
        logic [127:0] d;
        logic [15:0]  s;
        d32 = 32'(k) ^ 32'hA5A5_0000;
        d   = {d32, ~d32, d32 + 32'd1, d32 ^ 32'h0F0F_0F0F};
        s   = 16'(k * 7 + 1);
        return {s, d};
    endfunction

    task automatic update_fifo();
        fifo_empty = (gap_left > 0) || (fq.size() == 0);
        fifo_rdata = (fq.size() != 0) ? fq[0] : '0;
    endtask

    task automatic add_words(input int n);
        logic [143:0] w;
        for (int i = 0; i < n; i++) begin
            w = mk_word(word_id);
            word_id++;
            fq.push_back(w);
            exp_w.push_back(w);
        end
        update_fifo();
    endtask

    task automatic clr_stats();
        pops = 0; hs_cnt = 0; done_cnt = 0; acc = 0;
        first_hs = -1; last_hs = -1; stalls = 0; gap_seen = 0;
    endtask

    // One clock: observe at the falling edge, update the FIFO model just
    // after the rising edge.
    task automatic tick();
        logic         pop_s;
        logic [143:0] ew;
        logic         el;
        @(negedge clk);
        cyc++;
        if (fifo_pop) chk("pop_when_empty", fifo_empty, 0);
        if (prev_stall) begin
            chk("wvalid_hold", w_if.m_axi_wvalid, 1);
            chk("stall_hold", {w_if.m_axi_wlast, w_if.m_axi_wstrb, w_if.m_axi_wdata}, held);
        end
        chk("burst_done", burst_done, prev_hs_last);
        if (burst_done) done_cnt++;
        if (gap_left > 0 && gap_left < 20) begin
            chk("gap_wvalid", w_if.m_axi_wvalid, 0);
            gap_seen = 1;
        end
        if (w_if.m_axi_wvalid && w_if.m_axi_wready) begin
            hs_cnt++;
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
            if (exp_w.size() == 0 || exp_l.size() == 0) begin
                chk("unexpected_beat", 1, 0);
            end else begin
                ew = exp_w.pop_front();
                el = exp_l.pop_front();
                chk("wdata_wstrb", {w_if.m_axi_wstrb, w_if.m_axi_wdata}, ew);
                chk("wlast", w_if.m_axi_wlast, el);
            end
        end
        if (cmd_valid && cmd_ready) acc++;
        prev_stall   = w_if.m_axi_wvalid & ~w_if.m_axi_wready;
        if (prev_stall) stalls++;
        held         = {w_if.m_axi_wlast, w_if.m_axi_wstrb, w_if.m_axi_wdata};
        prev_hs_last = w_if.m_axi_wvalid & w_if.m_axi_wready & w_if.m_axi_wlast;
        pop_s        = fifo_pop;
        @(posedge clk);
        #1;
        if (gap_left > 0) gap_left--;
        if (pop_s) begin
            pops++;
            if (fq.size() != 0) ew = fq.pop_front();
            if (pops == gap_at) gap_left = 20;
        end
        if (toggle_rdy) w_if.m_axi_wready = ~w_if.m_axi_wready;
        update_fifo();
    endtask

    task automatic push_cmd(input int len);
        cmd_valid = 1'b1;
        cmd_len   = 8'(len);
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i <= len; i++) exp_l.push_back(i == len);
    endtask

    task automatic wait_done(input int n, input int budget);
        int k;
        k = 0;
        while (done_cnt < n && k < budget) begin
            tick();
            k++;
        end
        chk("timeout_done", done_cnt, n);
        tick();
        tick();
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_wvalid"}, w_if.m_axi_wvalid, 0);
        chk({tag, "_wdata"},  w_if.m_axi_wdata, 0);
        chk({tag, "_wstrb"},  w_if.m_axi_wstrb, 0);
        chk({tag, "_wlast"},  w_if.m_axi_wlast, 0);
        chk({tag, "_done"},   burst_done, 0);
        chk({tag, "_pop"},    fifo_pop, 0);
        chk({tag, "_busy"},   busy, 0);
        chk({tag, "_cready"}, cmd_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst       = 1'b1;
        soft_init = 1'b0;
        cmd_valid = 1'b0;
        cmd_len   = '0;
        w_if.m_axi_wready = 1'b1;
        cyc = 0;
        clr_stats();
        update_fifo();
        repeat (2) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        rst = 1'b0;

        // 1: four words waiting, nothing issued until a len=3 command.
        add_words(4);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_wvalid", w_if.m_axi_wvalid, 0);
            chk("idle_pop", fifo_pop, 0);
        end
        push_cmd(3);
        wait_done(1, 30);
        chk("t1_beats", hs_cnt, 4);
        chk("t1_pops", pops, 4);
        chk("t1_exp_left", exp_w.size(), 0);

        // 2: three single-beat bursts back to back, no bubbles.
        clr_stats();
        add_words(3);
        push_cmd(0);
        push_cmd(0);
        push_cmd(0);
        wait_done(3, 30);
        chk("t2_beats", hs_cnt, 3);
        chk("t2_consecutive", last_hs - first_hs, 2);

        // 3: len=7 with wready toggling every cycle.
        clr_stats();
        toggle_rdy = 1;
        add_words(8);
        push_cmd(7);
        wait_done(1, 60);
        toggle_rdy = 0;
        w_if.m_axi_wready = 1'b1;
        chk("t3_beats", hs_cnt, 8);
        chk("t3_pops_eq_hs", pops, hs_cnt);
        chk("t3_stalls_seen", stalls > 0, 1);

        // 4: 256-beat burst with a 20-cycle FIFO gap after 100 pops.
        clr_stats();
        gap_at = 100;
        add_words(256);
        push_cmd(255);
        wait_done(1, 600);
        gap_at = -1;
        chk("t4_beats", hs_cnt, 256);
        chk("t4_pops", pops, 256);
        chk("t4_gap_seen", gap_seen, 1);
        chk("t4_exp_left", exp_l.size(), 0);

        // 5: fill the command queue with no data present, then soft_init.
        clr_stats();
        cmd_valid = 1'b1;
        k = 0;
        while (acc < 5 && k < 10) begin
            cmd_len = 8'(k);
            tick();
            k++;
        end
        chk("t5_accepted", acc, 5);
        chk("t5_cmd_ready", cmd_ready, 0);
        chk("t5_busy", busy, 1);
        tick();
        tick();
        chk("t5_no_extra", acc, 5);
        cmd_valid = 1'b0;
        soft_init = 1'b1;
        tick();
        soft_init = 1'b0;
        chk_idle_outputs("soft_init");

        // 6: async reset mid-burst, then a clean 2-beat burst.
        clr_stats();
        add_words(8);
        push_cmd(7);
        k = 0;
        while (hs_cnt < 3 && k < 30) begin
            tick();
            k++;
        end
        chk("t6_reach_beat3", hs_cnt, 3);
        rst = 1'b1;
        #1;
        chk_idle_outputs("async_rst");
        fq.delete();
        exp_w.delete();
        exp_l.delete();
        prev_stall   = 1'b0;
        prev_hs_last = 1'b0;
        update_fifo();
        @(posedge clk);
        #1;
        rst = 1'b0;
        clr_stats();
        add_words(2);
        push_cmd(1);
        wait_done(1, 30);
        chk("t6_beats", hs_cnt, 2);
        chk("t6_exp_left", exp_w.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_axi_wdata_issue_sync_128b
`default_nettype wire
